// File: rtl/log_mul_pkg.sv
// Shared helpers for the Mitchell-style logarithmic multiplier: lane slicing,
// leading-one detection and the offset that sets the optional correction constant.
package log_mul_pkg;

  // Correction constant is 2^(WIDTH - CORR_OFFSET) in fraction units.
  localparam int CORR_OFFSET = 5;

  // Bit position of lane 'lane' in a bus of 'width'-bit lanes, lane 0 at the LSBs.
  function automatic int lane_base(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic logic [4:0] lead_one(input logic [31:0] x);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/log_mul_lane.sv
// One combinational logarithmic multiplier lane (unsigned or two's-complement).
// Defining LOG_MUL_CORR_EN adds a constant error correction to the fraction sum.
module log_mul_lane
  import log_mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TRUNC = 0
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] p
);

  localparam logic [4:0] WM1 = 5'(WIDTH - 1);

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [4:0]         ka, kb;
  logic [WIDTH-2:0]   fa, fb, fp, fp_adj;
  logic [WIDTH-1:0]   fsum;
  logic               carry, neg, zero;
  logic [5:0]         kp;
  logic [WIDTH-1:0]   mant;
  logic [3*WIDTH-2:0] wide;
  logic [2*WIDTH-1:0] magp;

  assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

  assign ka = lead_one(32'(mag_a));
  assign kb = lead_one(32'(mag_b));

  // Shift the leading one up to the MSB and drop it: what remains is the log fraction.
  assign fa = (WIDTH-1)'(mag_a << (WM1 - ka));
  assign fb = (WIDTH-1)'(mag_b << (WM1 - kb));

  generate
    if (TRUNC == 0) begin : g_exact
      assign fsum = {1'b0, fa} + {1'b0, fb};
    end else begin : g_trunc
      localparam int UW = WIDTH - 1 - TRUNC;
      logic          cin;
      logic [UW:0]   usum;
      assign cin  = fa[TRUNC] & fb[TRUNC];
      assign usum = {1'b0, fa[WIDTH-2:TRUNC]} + {1'b0, fb[WIDTH-2:TRUNC]} + (UW+1)'(cin);
      assign fsum = {usum, {TRUNC{1'b1}}};
    end
  endgenerate

  assign carry = fsum[WIDTH-1];
  assign fp    = fsum[WIDTH-2:0];
  assign kp    = 6'(ka) + 6'(kb) + 6'(carry);

`ifdef LOG_MUL_CORR_EN
  localparam logic [WIDTH-1:0] CORR_K = WIDTH'(1) << (WIDTH - CORR_OFFSET);
  logic [WIDTH-1:0] fp_inc;
  assign fp_inc = {1'b0, fp} + CORR_K;
  assign fp_adj = carry ? fp : (fp_inc[WIDTH-1] ? '1 : fp_inc[WIDTH-2:0]);
`else
  assign fp_adj = fp;
`endif

  // Antilog: 1.fp scaled by 2^kp, then the WIDTH-1 fraction bits are dropped.
  assign mant = {1'b1, fp_adj};
  assign wide = (3*WIDTH-1)'(mant) << kp;
  assign magp = (2*WIDTH)'(wide >> (WIDTH - 1));

  assign neg  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign zero = (a == '0) || (b == '0);
  assign p    = zero ? '0 : (neg ? -magp : magp);

endmodule

// File: rtl/log_mul_lanes.sv
// Multi-lane logarithmic multiplier with a stall-as-a-whole valid/ready pipeline.
// Build option LOG_MUL_CORR_EN enables fraction-sum error correction in every lane.
module log_mul_lanes
  import log_mul_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int TRUNC  = 0,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_signed,
  input  logic [LANES*WIDTH-1:0]   in_a,
  input  logic [LANES*WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     busy
);

  localparam int PW = LANES * 2 * WIDTH;

  logic [PW-1:0]     lane_p;
  logic [STAGES-1:0] valid_reg;
  logic [PW-1:0]     p_reg   [STAGES];
  logic [TAG_W-1:0]  tag_reg [STAGES];
  logic              advance;

  // The signed mode is consumed at entry, so it travels with the beat inside p_reg.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      log_mul_lane #(
        .WIDTH (WIDTH),
        .TRUNC (TRUNC)
      ) u_lane (
        .a         (in_a[lane_base(gi, WIDTH) +: WIDTH]),
        .b         (in_b[lane_base(gi, WIDTH) +: WIDTH]),
        .is_signed (in_signed),
        .p         (lane_p[lane_base(gi, 2*WIDTH) +: 2*WIDTH])
      );
    end
  endgenerate

  assign advance  = out_ready | ~valid_reg[STAGES-1];
  assign in_ready = advance & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        p_reg[i]   <= '0;
        tag_reg[i] <= '0;
      end
    end else if (advance) begin
      valid_reg[0] <= in_valid & in_ready;
      p_reg[0]     <= lane_p;
      tag_reg[0]   <= in_tag;
      for (int i = 1; i < STAGES; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        p_reg[i]     <= p_reg[i-1];
        tag_reg[i]   <= tag_reg[i-1];
      end
    end
  end

  assign out_valid = valid_reg[STAGES-1];
  assign out_p     = p_reg[STAGES-1];
  assign out_tag   = tag_reg[STAGES-1];
  assign busy      = |valid_reg;

endmodule

// File: tb/tb_log_mul_lanes.sv
// Scoreboard bench for log_mul_lanes: directed beats with hand-computed products,
// stall, latency and mid-stream reset scenarios.
module tb_log_mul_lanes;

  localparam int LANES  = 4;
  localparam int WIDTH  = 16;
  localparam int STAGES = 3;
  localparam int TRUNC  = 0;
  localparam int TAG_W  = 4;

  typedef struct packed {
    logic [127:0] p;
    logic [3:0]   tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [63:0]  in_a;
  logic [63:0]  in_b;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_p;
  logic [3:0]   out_tag;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t         sb_q[$];
  logic [63:0]  vec_a [4];
  logic [63:0]  vec_b [4];
  logic         vec_s [4];
  logic [127:0] vec_p [4];

  log_mul_lanes #(
    .LANES  (LANES),
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .TRUNC  (TRUNC),
    .TAG_W  (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int idx, input logic [3:0] tag);
    int guard;
    exp_t e;
    guard     = 0;
    in_valid  = 1'b1;
    in_a      = vec_a[idx];
    in_b      = vec_b[idx];
    in_signed = vec_s[idx];
    in_tag    = tag;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      check("send_timeout", 128'(in_ready), 128'd1);
    end else begin
      e.p   = vec_p[idx];
      e.tag = tag;
      sb_q.push_back(e);
      $display("send beat=%0d tag=%0d signed=%0b a=%h b=%h", idx, tag, vec_s[idx], vec_a[idx], vec_b[idx]);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      #3;
      guard++;
    end
    check("drain_empty", 128'(sb_q.size()), 128'd0);
    @(negedge clk);
  endtask

  // Monitor: any completed output transfer is compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got p=%h tag=%0d expected no beat", out_p, out_tag);
        end else begin
          e = sb_q.pop_front();
          $display("recv tag=%0d p=%h exp=%h", out_tag, out_p, e.p);
          check("out_p", out_p, e.p);
          check("out_tag", 128'(out_tag), 128'(e.tag));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;

    // Beat 0 (unsigned): 3*5, 8*8, 0xFFFF*2, 3*3
    vec_a[0] = {16'd3, 16'hFFFF, 16'd8, 16'd3};
    vec_b[0] = {16'd3, 16'd2, 16'd8, 16'd5};
    vec_s[0] = 1'b0;
    // Beat 1 (signed): -4*3, -32768*1, 0*(-7), -32768*-32768
    vec_a[1] = {16'h8000, 16'h0000, 16'h8000, 16'hFFFC};
    vec_b[1] = {16'h8000, 16'hFFF9, 16'h0001, 16'h0003};
    vec_s[1] = 1'b1;
    // Beat 2 (unsigned): 0xFFFF*0xFFFF, 0*5, 1*1, 0xFFFF*2
    vec_a[2] = {16'hFFFF, 16'd1, 16'd0, 16'hFFFF};
    vec_b[2] = {16'd2, 16'd1, 16'd5, 16'hFFFF};
    vec_s[2] = 1'b0;
    vec_p[2] = {32'h0001FFFE, 32'd1, 32'd0, 32'hFFFE0000};
    // Beat 3 (signed): -1*2, 3*5, -1*-1, 5*0
    vec_a[3] = {16'd5, 16'hFFFF, 16'd3, 16'hFFFF};
    vec_b[3] = {16'd0, 16'hFFFF, 16'd5, 16'd2};
    vec_s[3] = 1'b1;
    vec_p[3] = {32'd0, 32'd1, 32'd14, 32'hFFFFFFFE};
`ifdef LOG_MUL_CORR_EN
    vec_p[0] = {32'd8, 32'h0001FFFE, 32'd68, 32'd14};
    vec_p[1] = {32'h44000000, 32'h0, 32'hFFFF7800, 32'hFFFFFFF4};
`else
    vec_p[0] = {32'd8, 32'h0001FFFE, 32'd64, 32'd14};
    vec_p[1] = {32'h40000000, 32'h0, 32'hFFFF8000, 32'hFFFFFFF4};
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_p", out_p, 128'd0);
    check("rst_out_tag", 128'(out_tag), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);

    // Latency with out_ready held high
    send(0, 4'd1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 128'(lat), 128'(STAGES));
    wait_empty();

    send(1, 4'd2);
    send(2, 4'd3);
    send(3, 4'd4);
    wait_empty();

    // Mode alternates every beat
    send(2, 4'd5);
    send(3, 4'd6);
    send(2, 4'd7);
    send(3, 4'd8);
    wait_empty();

    // Backpressure with three beats in flight
    send(0, 4'd9);
    send(1, 4'd10);
    send(2, 4'd11);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", 128'(in_ready), 128'd0);
      check("stall_out_valid", 128'(out_valid), 128'd1);
      check("stall_out_p", out_p, sb_q[0].p);
      check("stall_out_tag", 128'(out_tag), 128'(sb_q[0].tag));
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_empty();

    // Reset while the pipeline is full and a result is on the output
    send(0, 4'd12);
    send(1, 4'd13);
    send(2, 4'd14);
    check("pre_rst_out_valid", 128'(out_valid), 128'd1);
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_out_p", out_p, 128'd0);
    check("midrst_out_tag", 128'(out_tag), 128'd0);
    rst = 1'b0;
    #1;
    check("after_midrst_in_ready", 128'(in_ready), 128'd1);
    repeat (6) @(negedge clk);
    check("idle_busy", 128'(busy), 128'd0);
    send(3, 4'd15);
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
